// File: rtl/sha_work_reg_bank.sv
// SHA-2 working-variable bank: a..h round-shift registers plus H0..H7 chaining value.
// Loads the chaining value on start, applies ROUNDS T1/T2 updates, then adds back.
module sha_work_reg_bank #(
    parameter int W      = 32,
    parameter int ROUNDS = 64,
    parameter int RW     = 7
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [8*W-1:0]  hash_i,
    input  logic            round_en,
    input  logic [W-1:0]    t1_i,
    input  logic [W-1:0]    t2_i,
    output logic [8*W-1:0]  work_o,
    output logic [RW-1:0]   round_o,
    output logic [8*W-1:0]  hash_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL
    } state_t;

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    state_t               state_q, state_d;
    logic [7:0][W-1:0]    work_q, work_d;
    logic [7:0][W-1:0]    h_q, h_d;
    logic [7:0][W-1:0]    hash_q, hash_d;
    logic [7:0][W-1:0]    sum;
    logic [RW-1:0]        round_q, round_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            sum[k] = h_q[k] + work_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        h_d     = h_q;
        hash_d  = hash_q;
        round_d = round_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    h_d     = hash_i;
                    work_d  = hash_i;
                    round_d = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (round_en) begin
                    work_d[7] = work_q[6];
                    work_d[6] = work_q[5];
                    work_d[5] = work_q[4];
                    work_d[4] = work_q[3] + t1_i;
                    work_d[3] = work_q[2];
                    work_d[2] = work_q[1];
                    work_d[1] = work_q[0];
                    work_d[0] = t1_i + t2_i;
                    if (round_q == LAST) begin
                        round_d = '0;
                        state_d = S_FINAL;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end
            end
            S_FINAL: begin
                // Keep the sum in H as well so the next block can chain from it.
                hash_d  = sum;
                h_d     = sum;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            h_q     <= '0;
            hash_q  <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            h_q     <= h_d;
            hash_q  <= hash_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign work_o  = work_q;
    assign hash_o  = hash_q;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
